// File: rtl/tmr_mon_pkg.sv
// Shared constants for the TMR mismatch monitor: counter select encoding and read-FSM states.
package tmr_mon_pkg;

   localparam logic [1:0] SEL_A = 2'd0;
   localparam logic [1:0] SEL_B = 2'd1;
   localparam logic [1:0] SEL_C = 2'd2;
   localparam logic [1:0] SEL_M = 2'd3;

   localparam int unsigned N_CNT = 4;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_ACK  = 2'd1,
      RD_DROP = 2'd2
   } rd_state_e;

endpackage

// File: rtl/tmr_mon_sat_counter.sv
// Saturating error counter with increment and clear; a clear that coincides
// with an increment leaves the counter at 1 so that event is not lost.
module tmr_mon_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = inc_i ? CNT_W'(1) : '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/tmr_mismatch_monitor.sv
// Majority voter over three replica words with per-replica error counters read via
// a four-phase handshake. Define TMR_MON_CLEAR_ON_READ_EN for destructive reads.
module tmr_mismatch_monitor
   import tmr_mon_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic [WIDTH-1:0] inC,
   output logic [WIDTH-1:0] voted_o,
   output logic             err_o,
   output logic             errA_o,
   output logic             errB_o,
   output logic             errC_o,
   output logic             errM_o,
   input  logic             rd_req,
   input  logic [1:0]       rd_sel,
   output logic             rd_ack,
   output logic [CNT_W-1:0] rd_data
);

   logic [WIDTH-1:0] maj_c, odd_a_c, odd_b_c, odd_c_c;
   logic [2:0]       odd_c;
   logic             diff_c;
   logic [N_CNT-1:0] inc, clr;
   logic [CNT_W-1:0] cnt [N_CNT];

   logic [WIDTH-1:0] voted_q;
   logic             err_q;
   logic [N_CNT-1:0] flag_q;

   rd_state_e        state_q, state_d;
   logic             rd_ack_q, rd_ack_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;

   // A replica is odd at a bit where it differs while the other two agree.
   assign maj_c   = (inA & inB) | (inA & inC) | (inB & inC);
   assign odd_a_c = (inA ^ inB) & ~(inB ^ inC);
   assign odd_b_c = (inB ^ inA) & ~(inA ^ inC);
   assign odd_c_c = (inC ^ inA) & ~(inA ^ inB);
   assign odd_c   = {|odd_c_c, |odd_b_c, |odd_a_c};
   assign diff_c  = |(odd_a_c | odd_b_c | odd_c_c);

   always_comb begin
      inc = '0;
      if (valid_i) begin
         case (odd_c)
            3'b000:  inc = '0;
            3'b001:  inc[SEL_A] = 1'b1;
            3'b010:  inc[SEL_B] = 1'b1;
            3'b100:  inc[SEL_C] = 1'b1;
            default: inc[SEL_M] = 1'b1;
         endcase
      end
   end

   for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
      tmr_mon_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rstn  (rstn),
         .inc_i (inc[g]),
         .clr_i (clr[g]),
         .cnt_o (cnt[g])
      );
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         voted_q <= '0;
         err_q   <= 1'b0;
         flag_q  <= '0;
      end else begin
         if (valid_i) voted_q <= maj_c;
         err_q  <= valid_i & diff_c;
         flag_q <= (flag_q & ~clr) | inc;
      end
   end

`ifdef TMR_MON_CLEAR_ON_READ_EN
   logic [1:0] sel_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                sel_q <= '0;
      else if (state_q == RD_IDLE && rd_req)    sel_q <= rd_sel;
   end

   // Destructive read: clear the counter that was just read on the ACK->DROP step.
   always_comb begin
      clr = '0;
      if (state_q == RD_ACK && !rd_req) clr[sel_q] = 1'b1;
   end
`else
   assign clr = '0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= RD_IDLE;
         rd_ack_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         rd_ack_q  <= rd_ack_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RD_IDLE: if (rd_req)  state_d = RD_ACK;
         RD_ACK:  if (!rd_req) state_d = RD_DROP;
         RD_DROP: state_d = RD_IDLE;
         default: state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      rd_ack_d  = 1'b0;
      rd_data_d = rd_data_q;
      case (state_q)
         RD_IDLE: begin
            if (rd_req) begin
               rd_ack_d  = 1'b1;
               rd_data_d = cnt[rd_sel];
            end
         end
         RD_ACK:  rd_ack_d = rd_req;
         default: rd_ack_d = 1'b0;
      endcase
   end

   assign voted_o = voted_q;
   assign err_o   = err_q;
   assign errA_o  = flag_q[SEL_A];
   assign errB_o  = flag_q[SEL_B];
   assign errC_o  = flag_q[SEL_C];
   assign errM_o  = flag_q[SEL_M];
   assign rd_ack  = rd_ack_q;
   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_tmr_mismatch_monitor.sv
// Self-checking bench for tmr_mismatch_monitor: directed cases plus random replica traffic
// against a per-bit behavioural model; honours TMR_MON_CLEAR_ON_READ_EN.
module tb_tmr_mismatch_monitor;
   import tmr_mon_pkg::*;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rstn;
   logic             valid_i;
   logic [WIDTH-1:0] inA, inB, inC;
   logic [WIDTH-1:0] voted_o;
   logic             err_o, errA_o, errB_o, errC_o, errM_o;
   logic             rd_req;
   logic [1:0]       rd_sel;
   logic             rd_ack;
   logic [CNT_W-1:0] rd_data;

   int unsigned      cnt_m [4];
   logic [3:0]       flag_m;
   logic [WIDTH-1:0] voted_m;
   int               clr_idx = -1;
   int               n_checks = 0;
   int               n_errors = 0;

   tmr_mismatch_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .valid_i (valid_i),
      .inA     (inA),
      .inB     (inB),
      .inC     (inC),
      .voted_o (voted_o),
      .err_o   (err_o),
      .errA_o  (errA_o),
      .errB_o  (errB_o),
      .errC_o  (errC_o),
      .errM_o  (errM_o),
      .rd_req  (rd_req),
      .rd_sel  (rd_sel),
      .rd_ack  (rd_ack),
      .rd_data (rd_data)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) cnt_m[k] = 0;
      flag_m  = '0;
      voted_m = '0;
   endtask

   // One clock with the currently driven inputs; model is updated and outputs checked after the edge.
   task automatic cycle();
      logic [2:0]       seen = '0;
      logic [WIDTH-1:0] maj  = '0;
      bit               diff = 1'b0;
      int               inc_idx = -1;
      if (valid_i) begin
         for (int i = 0; i < WIDTH; i++) begin
            int   ones = int'(inA[i]) + int'(inB[i]) + int'(inC[i]);
            logic minority = (ones == 1);
            maj[i] = (ones >= 2);
            if (ones == 1 || ones == 2) begin
               diff = 1'b1;
               if (inA[i] == minority) seen[0] = 1'b1;
               if (inB[i] == minority) seen[1] = 1'b1;
               if (inC[i] == minority) seen[2] = 1'b1;
            end
         end
         if ($countones(seen) == 1) begin
            for (int r = 0; r < 3; r++) if (seen[r]) inc_idx = r;
         end else if ($countones(seen) > 1) begin
            inc_idx = 3;
         end
      end
      @(posedge clk); #1;
      if (valid_i) voted_m = maj;
      for (int k = 0; k < 4; k++) begin
         if (k == clr_idx) begin
            cnt_m[k]  = (k == inc_idx) ? 1 : 0;
            flag_m[k] = (k == inc_idx);
         end else if (k == inc_idx) begin
            if (cnt_m[k] < CNT_MAX) cnt_m[k]++;
            flag_m[k] = 1'b1;
         end
      end
      check("voted", 32'(voted_o), 32'(voted_m));
      check("err_pulse", 32'(err_o), 32'(valid_i && diff));
      check("flags", 32'({errM_o, errC_o, errB_o, errA_o}), 32'(flag_m));
   endtask

   task automatic rand_inputs();
      logic [WIDTH-1:0] base = WIDTH'($urandom);
      logic [WIDTH-1:0] a = base, b = base, c = base;
      if ($urandom_range(0, 2) == 0) a ^= WIDTH'(1) << $urandom_range(0, WIDTH - 1);
      if ($urandom_range(0, 2) == 0) b ^= WIDTH'(1) << $urandom_range(0, WIDTH - 1);
      if ($urandom_range(0, 2) == 0) c ^= WIDTH'(1) << $urandom_range(0, WIDTH - 1);
      valid_i = ($urandom_range(0, 4) != 0);
      inA = a; inB = b; inC = c;
   endtask

   task automatic traffic(input bit active);
      if (active) rand_inputs();
      else valid_i = 1'b0;
   endtask

   // Full four-phase read; rd_sel is scrambled while acknowledged and rd_req is pulsed during DROP.
   task automatic do_read(input logic [1:0] sel, input int hold, input bit active);
      int unsigned exp = cnt_m[sel];
      rd_sel = sel;
      rd_req = 1'b1;
      traffic(active);
      cycle();
      check("rd_ack_rise", 32'(rd_ack), 32'd1);
      check("rd_data", 32'(rd_data), 32'(exp));
      for (int h = 1; h < hold; h++) begin
         rd_sel = 2'($urandom_range(0, 3));
         traffic(active);
         cycle();
         check("rd_ack_hold", 32'(rd_ack), 32'd1);
         check("rd_data_hold", 32'(rd_data), 32'(exp));
      end
      rd_req = 1'b0;
`ifdef TMR_MON_CLEAR_ON_READ_EN
      clr_idx = int'(sel);
`endif
      traffic(active);
      cycle();
      clr_idx = -1;
      check("rd_ack_fall", 32'(rd_ack), 32'd0);
      rd_req = 1'b1;
      traffic(active);
      cycle();
      check("rd_ack_drop", 32'(rd_ack), 32'd0);
      rd_req = 1'b0;
      traffic(active);
      cycle();
      check("rd_ack_idle", 32'(rd_ack), 32'd0);
   endtask

   initial begin
      rstn = 1'b0; valid_i = 1'b0; inA = '0; inB = '0; inC = '0;
      rd_req = 1'b0; rd_sel = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_voted", 32'(voted_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_flags", 32'({errM_o, errC_o, errB_o, errA_o}), 32'd0);
      check("rst_ack", 32'(rd_ack), 32'd0);
      check("rst_data", 32'(rd_data), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Agreeing replicas
      valid_i = 1'b1; inA = 8'h5A; inB = 8'h5A; inC = 8'h5A;
      cycle();
      check("agree_voted", 32'(voted_o), 32'h5A);
      check("agree_err", 32'(err_o), 32'd0);
      // Single odd replica A
      inA = 8'h5B;
      cycle();
      check("oddA_voted", 32'(voted_o), 32'h5A);
      check("oddA_err", 32'(err_o), 32'd1);
      check("oddA_flag", 32'(errA_o), 32'd1);
      valid_i = 1'b0;
      cycle();
      check("err_one_cycle", 32'(err_o), 32'd0);
      // A and B odd at different bits -> multi-replica error
      valid_i = 1'b1; inA = 8'h01; inB = 8'h02; inC = 8'h00;
      cycle();
      check("multi_voted", 32'(voted_o), 32'h00);
      check("multi_flagM", 32'(errM_o), 32'd1);
      check("multi_flagB", 32'(errB_o), 32'd0);
      valid_i = 1'b0;
      cycle();
      check("hold_voted", 32'(voted_o), 32'h00);
      do_read(SEL_A, 1, 1'b0);
      do_read(SEL_B, 2, 1'b0);
      do_read(SEL_M, 1, 1'b0);

      // Counter C to 3, then a 3-cycle read and a follow-up read
      valid_i = 1'b1; inA = 8'h00; inB = 8'h00; inC = 8'h04;
      repeat (3) cycle();
      valid_i = 1'b0;
      do_read(SEL_C, 3, 1'b0);
      do_read(SEL_C, 1, 1'b0);

      // Saturation of counter B
      valid_i = 1'b1; inA = 8'h33; inB = 8'hB3; inC = 8'h33;
      repeat (20) cycle();
      valid_i = 1'b0;
      do_read(SEL_B, 1, 1'b0);

      // Random traffic with interleaved reads
      for (int n = 0; n < 400; n++) begin
         rand_inputs();
         cycle();
         if ($urandom_range(0, 15) == 0)
            do_read(2'($urandom_range(0, 3)), $urandom_range(1, 4), 1'b1);
      end
      for (int s = 0; s < 4; s++) do_read(2'(s), 1, 1'b0);

      // Reset in the middle of a handshake, with rd_req still high afterwards
      valid_i = 1'b0; rd_sel = SEL_B; rd_req = 1'b1;
      cycle();
      check("pre_rst_ack", 32'(rd_ack), 32'd1);
      #3 rstn = 1'b0;
      #1;
      model_reset();
      check("async_rst_ack", 32'(rd_ack), 32'd0);
      check("async_rst_data", 32'(rd_data), 32'd0);
      check("async_rst_flags", 32'({errM_o, errC_o, errB_o, errA_o}), 32'd0);
      check("async_rst_voted", 32'(voted_o), 32'd0);
      @(posedge clk); #2;
      rstn = 1'b1;
      cycle();
      check("post_rst_ack", 32'(rd_ack), 32'd1);
      check("post_rst_data", 32'(rd_data), 32'd0);
      rd_req = 1'b0;
      cycle();
      cycle();
      for (int s = 0; s < 4; s++) do_read(2'(s), 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
